fetch_pc_queue: RTL and testbench

Parametrised successor to the single PC register in the fetch stage. It generates sequential PCs and issues them to instruction memory over a valid/ready request channel. In-order responses are buffered with their PCs in a DEPTH-entry queue that feeds decode. A redirect from execute reloads the PC, clears the queue and discards stale in-flight responses, replacing the old flush-to-zero behaviour.

---
 rtl/rv32i_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_pc_queue.sv | 112 +++++++++++
 tb/tb_fetch_pc_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-path widths, reset vector and the fetch queue entry.
package rv32i_pkg;

    localparam int DPW  = 32;
    localparam int ILEN = 32;

    localparam logic [DPW-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [DPW-1:0]  pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: synchronous FIFO of PC/instruction pairs with a
// synchronous clear used on redirect.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; readers gate the head with count.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !clear && !pop && count == CW'(DEPTH)));

    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(pop && count == '0));

endmodule

// File: rtl/fetch_pc_queue.sv
// Fetch stage PC generator with credit-limited imem requests, an
// in-order response queue to decode, and redirect with stale-drop.
module fetch_pc_queue
    import rv32i_pkg::*;
#(
    parameter int DPW                    = rv32i_pkg::DPW,
    parameter int ILEN                   = rv32i_pkg::ILEN,
    parameter int DEPTH                  = 4,
    parameter logic [DPW-1:0] RESET_VECTOR = rv32i_pkg::RESET_VECTOR,
    parameter int INSTR_BYTES            = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en_i,
    input  logic            redirect_i,
    input  logic [DPW-1:0]  redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [DPW-1:0]  imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [ILEN-1:0] imem_rsp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [DPW-1:0]  instr_pc_o,
    output logic [ILEN-1:0] instr_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [DPW-1:0] STEP = DPW'(INSTR_BYTES);
    localparam logic [DPW-1:0] MASK = ~DPW'(INSTR_BYTES - 1);

    logic [DPW-1:0] pc_q;
    logic [DPW-1:0] rsp_pc_q;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  drop_cnt;
    logic [CW-1:0]  count;
    logic [CW:0]    used;
    logic [DPW-1:0] target;

    logic req_fire;
    logic rsp_drop;
    logic rsp_take;
    logic rsp_any;
    logic pop;
    logic has;

    fetch_entry_t wentry;
    fetch_entry_t head;

    assign used   = {1'b0, count} + {1'b0, outstanding};
    assign target = redirect_pc_i & MASK;

    assign imem_req_valid_o = !rst && fetch_en_i && !redirect_i
                              && (used < (CW + 1)'(DEPTH));
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    // Stale responses are owed to drop_cnt and always go first in order.
    assign rsp_drop = imem_rsp_valid_i && (drop_cnt != '0);
    assign rsp_any  = imem_rsp_valid_i
                      && ((drop_cnt != '0) || (outstanding != '0));
    assign rsp_take = imem_rsp_valid_i && (drop_cnt == '0)
                      && (outstanding != '0) && !redirect_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_VECTOR;
            rsp_pc_q    <= RESET_VECTOR;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_i) begin
            pc_q        <= target;
            rsp_pc_q    <= target;
            outstanding <= '0;
            drop_cnt    <= drop_cnt + outstanding - CW'(rsp_any);
        end else begin
            if (req_fire) pc_q     <= pc_q + STEP;
            if (rsp_take) rsp_pc_q <= rsp_pc_q + STEP;
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
            drop_cnt    <= drop_cnt - CW'(rsp_drop);
        end
    end

    assign wentry = '{pc: rsp_pc_q, instr: imem_rsp_data_i};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_take),
        .pop   (pop),
        .clear (redirect_i),
        .wdata (wentry),
        .rdata (head),
        .count (count)
    );

    assign has           = (count != '0);
    assign instr_valid_o = has && !redirect_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_pc_o    = has ? head.pc : '0;
    assign instr_o       = has ? head.instr : '0;

    a_rsp_expected : assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid_i && drop_cnt == '0 && outstanding == '0));

    a_total_bound : assert property (@(posedge clk) disable iff (rst)
        ({2'b0, count} + {2'b0, outstanding} + {2'b0, drop_cnt})
            <= (CW + 2)'(DEPTH));

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Directed and random stimulus for fetch_pc_queue against a
// request/response level reference model with an in-order memory.
module tb_fetch_pc_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        instr_ready = 1'b0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] instr;

    fetch_pc_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_en_i       (fetch_en),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (mem_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .instr_pc_o       (instr_pc),
        .instr_o          (instr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    flight_t inflight[$];
    ent_t    dq[$];
    mreq_t   memq[$];

    logic [31:0] exp_pc = '0;
    bit          mem_go = 1'b0;
    int          lat = 1;
    int          cyc = 0;
    int          issued = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] memdata(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic int live();
        int n = 0;
        foreach (inflight[i]) if (!inflight[i].stale) n++;
        return n;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One clock: drive memory, compare, then advance the model at the edge.
    task automatic cycle();
        bit    exp_rv, exp_iv, fire, rsp, pop;
        flight_t f;
        mem_ready = mem_go && (memq.size() < DEPTH);
        rsp_valid = (memq.size() > 0) && (memq[0].due <= cyc);
        rsp_data  = rsp_valid ? memdata(memq[0].addr) : 32'h0;
        #1;
        exp_rv = fetch_en && !redirect && (dq.size() + live() < DEPTH);
        exp_iv = (dq.size() != 0) && !redirect;
        chk("req_valid", req_valid, exp_rv);
        chk("req_addr", req_addr, exp_pc);
        chk("instr_valid", instr_valid, exp_iv);
        if (exp_iv) begin
            chk("instr_pc", instr_pc, dq[0].pc);
            chk("instr", instr, dq[0].data);
        end
        fire = exp_rv && mem_ready;
        rsp  = rsp_valid;
        pop  = exp_iv && instr_ready;
        @(posedge clk);
        if (rsp) begin
            void'(memq.pop_front());
            if (inflight.size() > 0) begin
                f = inflight.pop_front();
                if (!f.stale && !redirect)
                    dq.push_back('{f.addr, memdata(f.addr)});
            end
        end
        if (req_valid && mem_ready) begin
            memq.push_back('{req_addr, cyc + lat});
            issued++;
        end
        if (pop) void'(dq.pop_front());
        if (redirect) begin
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            dq.delete();
            exp_pc = redirect_pc & ~32'h3;
        end else if (fire) begin
            inflight.push_back('{exp_pc, 1'b0});
            exp_pc += 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        rsp_valid = 1'b0;
        #1;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_req_addr", req_addr, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        inflight.delete();
        dq.delete();
        memq.delete();
        exp_pc = 32'h0;
    endtask

    initial begin
        bit          found;
        int          exp_drop;
        logic [31:0] hold;

        @(negedge clk);
        do_reset();

        // Streaming start: first decode-valid two cycles after first accept
        fetch_en = 1; mem_go = 1; instr_ready = 1; lat = 1;
        cycle();
        cycle();
        #1;
        chk("t1_first_valid", instr_valid, 1);
        chk("t1_first_pc", instr_pc, 32'h0);
        chk("t1_first_data", instr, memdata(32'h0));
        repeat (8) cycle();

        // Decode stalled: credit caps requests at DEPTH
        fetch_en = 0;
        repeat (5) cycle();
        fetch_en = 1; instr_ready = 0; issued = 0;
        repeat (10) cycle();
        chk("t2_issued", issued, DEPTH);
        instr_ready = 1;
        #1 chk("t2_no_req_at_pop", req_valid, 0);
        cycle();
        #1 chk("t2_req_after_pop", req_valid, 1);
        cycle();

        // Memory back-pressure holds the address
        hold = exp_pc;
        mem_go = 0;
        repeat (3) cycle();
        chk("t3_addr_hold", req_addr, hold);
        mem_go = 1;
        repeat (4) cycle();

        // Redirect with two outstanding on a 2-cycle memory
        lat = 2;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (live() == 2) found = 1;
            else cycle();
        end
        chk("t4_two_outstanding", found, 1);
        redirect = 1; redirect_pc = 32'h103;
        cycle();
        redirect = 0;
        #1 chk("t4_next_addr", req_addr, 32'h100);
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle();
            if (dq.size() != 0) found = 1;
        end
        chk("t4_refill", found, 1);
        #1 chk("t4_first_pc", instr_pc, 32'h100);

        // Redirect coinciding with a response and a pop, count=2
        fetch_en = 0;
        repeat (8) cycle();
        fetch_en = 1; instr_ready = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (dq.size() == 2 && memq.size() > 0 && memq[0].due <= cyc) begin
                found = 1;
                exp_drop = inflight.size() - 1;
                redirect = 1; redirect_pc = 32'h200; instr_ready = 1;
                cycle();
                redirect = 0;
                chk("t5_drop_cnt", 32'(dut.drop_cnt), exp_drop);
                chk("t5_count", 32'(dut.count), 0);
            end else begin
                cycle();
            end
        end
        chk("t5_found", found, 1);
        repeat (6) cycle();

        // Address wrap, then reset mid-stream
        lat = 1;
        redirect = 1; redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect = 0;
        cycle();
        cycle();
        #1 chk("t6_wrap_addr", req_addr, 32'h0);
        repeat (3) cycle();
        do_reset();
        repeat (5) cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            fetch_en    = ($urandom_range(99) < 85);
            mem_go      = ($urandom_range(99) < 70);
            instr_ready = ($urandom_range(99) < 65);
            lat         = $urandom_range(3, 1);
            redirect    = ($urandom_range(99) < 4);
            redirect_pc = $urandom();
            cycle();
            if (i == 1500) do_reset();
        end
        redirect = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
